// File: rtl/uart_ctrl_regs.sv
// UART register/sequencing controller: CTRL shadow with idle-gated apply,
// TX and RX byte FIFOs, and a registered single-cycle read port.
module uart_ctrl_regs #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  addr,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        rd_valid,
  output logic [10:0] cfg,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic        tx_busy,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_busy
);

  typedef struct packed {
    logic [7:0] br_div;
    logic       word;
    logic       stop;
    logic       en;
  } config_t;

  typedef struct packed {
    logic [1:0] rsvd;
    logic       cfg_pending;
    logic       txf;
    logic       rxe;
    config_t    cfg;
  } ctrl_reg_t;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam int TXF = 0;
  localparam int RXF = 1;

  config_t    shadow_reg;
  config_t    cfg_reg;
  logic       cfg_pending_reg;
  logic       ctrl_wr;
  logic       cfg_apply;
  ctrl_reg_t  ctrl_rd;
  logic [15:0] rdata_reg;
  logic        rd_valid_reg;

  logic [1:0] push_req;
  logic [1:0] pop_req;
  logic [1:0] push_ok;
  logic [1:0] fifo_full;
  logic [1:0] fifo_empty;
  logic [7:0] fifo_din  [2];
  logic [7:0] fifo_head [2];

  logic unused_wdata_bits;
  assign unused_wdata_bits = ^wdata[15:11];

  assign ctrl_wr   = wr_en && (addr == 2'd0);
  assign cfg_apply = cfg_pending_reg && !tx_busy && !rx_busy;

  // A write landing on an apply edge goes straight to the engines.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_reg      <= '0;
      cfg_reg         <= '0;
      cfg_pending_reg <= 1'b0;
    end else if (ctrl_wr) begin
      shadow_reg <= wdata[10:0];
      if (cfg_apply) begin
        cfg_reg         <= wdata[10:0];
        cfg_pending_reg <= 1'b0;
      end else begin
        cfg_pending_reg <= 1'b1;
      end
    end else if (cfg_apply) begin
      cfg_reg         <= shadow_reg;
      cfg_pending_reg <= 1'b0;
    end
  end

  assign tx_valid = !fifo_empty[TXF] && cfg_reg.en;
  assign tx_data  = fifo_head[TXF];
  assign cfg      = cfg_reg;

  assign push_req     = {rx_valid, wr_en && (addr == 2'd1)};
  assign pop_req      = {rd_en && (addr == 2'd2) && !fifo_empty[RXF], tx_valid && tx_ready};
  assign fifo_din[TXF] = wdata[7:0];
  assign fifo_din[RXF] = rx_data;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fifo
      logic [7:0]    mem [DEPTH];
      logic [PW-1:0] wr_ptr_reg;
      logic [PW-1:0] rd_ptr_reg;
      logic [CW-1:0] count_reg;

      assign fifo_full[gi]  = (count_reg == FULL_COUNT);
      assign fifo_empty[gi] = (count_reg == '0);
      assign fifo_head[gi]  = mem[rd_ptr_reg];
      // A pop frees the slot in the same edge, so a full FIFO can still take a push.
      assign push_ok[gi]    = push_req[gi] && (!fifo_full[gi] || pop_req[gi]);

      always_ff @(posedge clk) begin
        if (push_ok[gi]) mem[wr_ptr_reg] <= fifo_din[gi];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
        end else begin
          if (push_ok[gi]) wr_ptr_reg <= wr_ptr_reg + 1'b1;
          if (pop_req[gi]) rd_ptr_reg <= rd_ptr_reg + 1'b1;
          if (push_ok[gi] && !pop_req[gi]) begin
            count_reg <= count_reg + 1'b1;
          end else if (!push_ok[gi] && pop_req[gi]) begin
            count_reg <= count_reg - 1'b1;
          end
        end
      end
    end
  endgenerate

  always_comb begin
    ctrl_rd             = '0;
    ctrl_rd.cfg_pending = cfg_pending_reg;
    ctrl_rd.txf         = fifo_full[TXF];
    ctrl_rd.rxe         = fifo_empty[RXF];
    ctrl_rd.cfg         = shadow_reg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_reg    <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      rd_valid_reg <= rd_en;
      rdata_reg    <= '0;
      if (rd_en) begin
        unique case (addr)
          2'd0:    rdata_reg <= ctrl_rd;
          2'd2:    if (!fifo_empty[RXF]) rdata_reg <= {8'h00, fifo_head[RXF]};
          default: rdata_reg <= '0;
        endcase
      end
    end
  end

  assign rdata    = rdata_reg;
  assign rd_valid = rd_valid_reg;

endmodule

// File: tb/tb_uart_ctrl_regs.sv
// Directed bench for uart_ctrl_regs: queue-based reference model compared
// every cycle, plus literal expectations from hand-worked vectors.
module tb_uart_ctrl_regs;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  addr;
  logic        wr_en, rd_en;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        rd_valid;
  logic [10:0] cfg;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready, tx_busy;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_busy;

  int checks = 0;
  int errors = 0;

  uart_ctrl_regs #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wr_en(wr_en), .rd_en(rd_en),
    .wdata(wdata), .rdata(rdata), .rd_valid(rd_valid), .cfg(cfg),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_busy(tx_busy), .rx_data(rx_data), .rx_valid(rx_valid), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain queues and the CTRL rules.
  logic [7:0]  m_txq[$];
  logic [7:0]  m_rxq[$];
  logic [10:0] m_shadow = '0;
  logic [10:0] m_cfg = '0;
  logic        m_pend = 1'b0;
  logic [15:0] m_rdata = '0;
  logic        m_rd_valid = 1'b0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_txq.delete();
      m_rxq.delete();
      m_shadow = '0; m_cfg = '0; m_pend = 1'b0;
      m_rdata = '0; m_rd_valid = 1'b0;
    end else begin
      logic tpop, rpop, apply;
      tpop  = (m_txq.size() != 0) && m_cfg[0] && tx_ready;
      rpop  = rd_en && (addr == 2'd2) && (m_rxq.size() != 0);
      apply = m_pend && !tx_busy && !rx_busy;
      m_rd_valid = rd_en;
      m_rdata = '0;
      if (rd_en && addr == 2'd0)
        m_rdata = {2'b00, m_pend, m_txq.size() == DEPTH, m_rxq.size() == 0, m_shadow};
      if (rpop) m_rdata = {8'h00, m_rxq[0]};
      if (tpop) void'(m_txq.pop_front());
      if (rpop) void'(m_rxq.pop_front());
      if (wr_en && addr == 2'd1 && m_txq.size() < DEPTH) m_txq.push_back(wdata[7:0]);
      if (rx_valid && m_rxq.size() < DEPTH) m_rxq.push_back(rx_data);
      if (wr_en && addr == 2'd0) begin
        m_shadow = wdata[10:0];
        if (apply) begin m_cfg = wdata[10:0]; m_pend = 1'b0; end
        else m_pend = 1'b1;
      end else if (apply) begin
        m_cfg = m_shadow; m_pend = 1'b0;
      end
    end
  end

  // Compare on the falling edge, away from the active edge.
  initial forever begin
    logic mv;
    @(negedge clk);
    mv = (m_txq.size() != 0) && m_cfg[0];
    chk("cfg", {5'b0, cfg}, {5'b0, m_cfg});
    chk("tx_valid", {15'b0, tx_valid}, {15'b0, mv});
    if (mv) chk("tx_data", {8'b0, tx_data}, {8'b0, m_txq[0]});
    chk("rd_valid", {15'b0, rd_valid}, {15'b0, m_rd_valid});
    if (m_rd_valid) chk("rdata", rdata, m_rdata);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    addr = a; wdata = d; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [15:0] exp, input string name);
    addr = a; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk({name, "_rd_valid"}, {15'b0, rd_valid}, 16'h0001);
    chk(name, rdata, exp);
  endtask

  initial begin
    addr = '0; wr_en = 0; rd_en = 0; wdata = '0;
    tx_ready = 0; tx_busy = 0; rx_data = '0; rx_valid = 0; rx_busy = 0;
    repeat (2) tick();
    #1 rst = 1'b0;
    tick();
    chk("reset_cfg", {5'b0, cfg}, 16'h0000);
    chk("reset_tx_valid", {15'b0, tx_valid}, 16'h0000);
    rd(2'd0, 16'h0800, "reset_ctrl");

    // Idle apply: 1 cycle write-to-apply
    wr(2'd0, 16'h0409);
    chk("apply_not_yet", {5'b0, cfg}, 16'h0000);
    tick();
    chk("apply_idle", {5'b0, cfg}, 16'h0409);
    rd(2'd0, 16'h0C09, "ctrl_after_apply");

    // Deferred apply while transmitter busy
    tx_busy = 1'b1;
    wr(2'd0, 16'h0011);
    rd(2'd0, 16'h2811, "ctrl_pending");
    chk("cfg_held", {5'b0, cfg}, 16'h0409);
    tx_busy = 1'b0;
    tick();
    chk("cfg_deferred", {5'b0, cfg}, 16'h0011);

    // TX overflow: A4 dropped
    for (int i = 0; i < 5; i++) wr(2'd1, 16'h00A0 + 16'(i));
    rd(2'd0, 16'h1811, "ctrl_txf");
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("tx_pop_valid", {15'b0, tx_valid}, 16'h0001);
      chk("tx_pop_data", {8'b0, tx_data}, 16'h00A0 + 16'(i));
      tick();
    end
    chk("tx_drained", {15'b0, tx_valid}, 16'h0000);
    tx_ready = 1'b0;

    // Push while full with a simultaneous pop
    for (int i = 0; i < 4; i++) wr(2'd1, 16'h00B0 + 16'(i));
    addr = 2'd1; wdata = 16'h00B4; wr_en = 1'b1; tx_ready = 1'b1;
    tick();
    wr_en = 1'b0; tx_ready = 1'b0;
    rd(2'd0, 16'h1811, "ctrl_txf_after_swap");
    tx_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      chk("tx_swap_data", {8'b0, tx_data}, 16'h00B0 + 16'(i));
      tick();
    end
    chk("tx_swap_drained", {15'b0, tx_valid}, 16'h0000);
    tx_ready = 1'b0;

    // RX path
    rx_data = 8'h55; rx_valid = 1'b1; tick();
    rx_data = 8'h3C; tick();
    rx_valid = 1'b0;
    rd(2'd0, 16'h0011, "ctrl_rx_nonempty");
    rd(2'd2, 16'h0055, "rx_first");
    rd(2'd2, 16'h003C, "rx_second");
    rd(2'd2, 16'h0000, "rx_empty");
    rd(2'd0, 16'h0811, "ctrl_rxe_back");

    // RX overflow: fifth byte dropped
    for (int i = 0; i < 5; i++) begin
      rx_data = 8'h10 + 8'(i); rx_valid = 1'b1; tick();
    end
    rx_valid = 1'b0;
    for (int i = 0; i < 4; i++) rd(2'd2, 16'h0010 + 16'(i), "rx_ovf");
    rd(2'd2, 16'h0000, "rx_ovf_empty");

    // RX push while full alongside a bus pop
    for (int i = 0; i < 4; i++) begin
      rx_data = 8'h20 + 8'(i); rx_valid = 1'b1; tick();
    end
    rx_data = 8'h24; addr = 2'd2; rd_en = 1'b1;
    tick();
    rx_valid = 1'b0; rd_en = 1'b0;
    chk("rx_swap_head", rdata, 16'h0020);
    for (int i = 1; i < 5; i++) rd(2'd2, 16'h0020 + 16'(i), "rx_swap");
    rd(2'd2, 16'h0000, "rx_swap_empty");

    // Enable gate
    wr(2'd0, 16'h0010);
    tick();
    chk("cfg_disabled", {5'b0, cfg}, 16'h0010);
    tx_ready = 1'b1;
    wr(2'd1, 16'h00C0);
    wr(2'd1, 16'h00C1);
    for (int i = 0; i < 3; i++) begin
      chk("gate_hold", {15'b0, tx_valid}, 16'h0000);
      tick();
    end
    wr(2'd0, 16'h0011);
    chk("gate_pending", {15'b0, tx_valid}, 16'h0000);
    tick();
    chk("gate_first", {8'b0, tx_data}, 16'h00C0);
    tick();
    chk("gate_second", {8'b0, tx_data}, 16'h00C1);
    tick();
    chk("gate_drained", {15'b0, tx_valid}, 16'h0000);
    tx_ready = 1'b0;

    // Reserved and TXDATA reads
    wr(2'd3, 16'hFFFF);
    rd(2'd3, 16'h0000, "reserved_rd");
    rd(2'd1, 16'h0000, "txdata_rd");
    rd(2'd0, 16'h0811, "ctrl_after_reserved");

    // Reset mid-traffic
    wr(2'd1, 16'h00D0);
    wr(2'd1, 16'h00D1);
    wr(2'd1, 16'h00D2);
    tx_busy = 1'b1;
    wr(2'd0, 16'h07FF);
    rx_data = 8'h77; rx_valid = 1'b1; tick();
    rx_valid = 1'b0;
    chk("pre_reset_tx_valid", {15'b0, tx_valid}, 16'h0001);
    #1 rst = 1'b1;
    tick();
    chk("mid_reset_cfg", {5'b0, cfg}, 16'h0000);
    chk("mid_reset_tx_valid", {15'b0, tx_valid}, 16'h0000);
    chk("mid_reset_rdata", rdata, 16'h0000);
    #1 rst = 1'b0;
    tx_busy = 1'b0;
    tick();
    rd(2'd0, 16'h0800, "ctrl_after_reset");
    rd(2'd2, 16'h0000, "rx_after_reset");
    chk("cfg_after_reset", {5'b0, cfg}, 16'h0000);

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
